max_stream_tx: RTL
==================

Name: max_stream_tx

Overview:
- Transmit-side framer for the running-max consumer.
- Buffers words written by a host into a small FIFO.
- On a send command, emits them as one frame: a start qualifier held high for exactly one cycle per word, with the data presented alongside, then start dropped.
- Waits for the consumer's done, captures the reported maximum, and returns it to the host with a one-cycle valid pulse; a watchdog flags a missing done.

Parameters:
- W, 8: data word width.
- DEPTH, 8: FIFO depth in words; must be a power of 2 and at least 2.
- TIMEOUT, 15: cycles to wait for done_in after the frame ends before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe.
- wr_data  in  W  host write data.
- full  out  1  FIFO full or block busy; writes are dropped while high.
- send  in  1  request to transmit the buffered frame (level sampled each edge).
- busy  out  1  high from send acceptance until result or error.
- start  out  1  frame qualifier to the consumer.
- data_out  out  W  frame word to the consumer.
- done_in  in  1  consumer end-of-frame indication.
- max_in  in  W  consumer maximum, valid while done_in=1.
- result  out  W  last captured maximum.
- result_valid  out  1  one-cycle pulse when result updates.
- err  out  1  sticky timeout flag; cleared by rst or the next accepted send.
- chk_err  out  1  self-check mismatch flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high), any state: FIFO emptied (count=0, pointers 0), state IDLE. All outputs 0: start, data_out, busy, result, result_valid, err, chk_err. full=0.
- FIFO:
  - count is $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
  - Write is accepted when wr_en=1, state IDLE and count<DEPTH.
  - full = (count==DEPTH) | busy.
  - No pop occurs in IDLE, so a write never coincides with a pop.
- State IDLE:
  - send=1 with count>0: latch len=count, clear err, busy<=1, go STREAM.
  - send=1 with count=0: ignored; busy stays 0.
  - send while busy is ignored in every state.
- State STREAM:
  - Each edge pops the FIFO head into the data_out register and sets start<=1.
  - After len pops, the next edge clears start and enters WAIT_DONE.
  - start is therefore high for exactly len consecutive cycles, with data_out holding word i in cycle i.
  - data_out holds the last word after start falls.
  - Latency: send sampled at edge 0 gives start=1 and data_out=word0 after edge 1.
- State WAIT_DONE:
  - Entered in the first cycle with start=0; the consumer asserts done_in combinationally in that same cycle.
  - done_in sampled 1: result<=max_in, result_valid<=1 for one cycle, busy<=0, go IDLE.
  - A timeout counter starts at 0 on entry. If done_in has not been seen after TIMEOUT cycles: err<=1, busy<=0, go IDLE, result unchanged.
- done_in outside WAIT_DONE is ignored.
- A frame never carries more than DEPTH words.

Optional Feature:
- Macro: MAX_STREAM_TX_SELF_CHECK_EN.
- Defined:
  - An internal register tracks the unsigned maximum of words popped during STREAM; it is cleared on send acceptance.
  - On result capture, chk_err<=1 (sticky until rst) if max_in differs from the tracked maximum.
- Not defined: no tracking logic is built and chk_err is tied to 0.

Test Plan:
- Write 2,1,3,7,0; pulse send. Required: start high for exactly 5 cycles, data_out sequence 2,1,3,7,0. Drive done_in=1 with max_in=7 in the first start-low cycle. Required: result=7, result_valid one cycle, busy=0.
- send with the FIFO empty. Required: start and busy stay 0; result and err unchanged.
- Write 9 words 10..18. Required: full=1 after the 8th write, 18 dropped. Send gives 8 start cycles, data 10..17.
- Send a 3-word frame and never assert done_in. Required: 15 cycles after start falls, err=1, busy=0, result unchanged. Then a new send clears err.
- Assert rst in the 2nd start cycle of a 4-word frame. Required: start, busy and full drop to 0 immediately (asynchronously). A following send with no writes does nothing.
- With MAX_STREAM_TX_SELF_CHECK_EN defined: send 4,9,5 and return max_in=5. Required: chk_err=1 and result=5. A repeat frame returning 9 gives chk_err still 1 (sticky).

Source files
------------

// File: rtl/max_stream_tx.sv
// max_stream_tx: buffers host words in a FIFO and sends them as one start-qualified frame, then returns the consumer's maximum.
// Latency: send sampled at edge 0 -> start=1/data_out=word0 after edge 1; result one edge after done_in is sampled.
// Backpressure: full (FIFO full or busy) drops writes; send is ignored while busy; optional MAX_STREAM_TX_SELF_CHECK_EN cross-checks max_in.
module max_stream_tx #(
  parameter int W       = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         send,
  output logic         busy,
  output logic         start,
  output logic [W-1:0] data_out,
  input  logic         done_in,
  input  logic [W-1:0] max_in,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err,
  output logic         chk_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] len;
  logic [CW-1:0] sent;
  logic [TW-1:0] tcnt;
  logic          wr_acc;
  logic          send_acc;
  logic          pop;
  logic [W-1:0]  head;

  // Writes only land while idle, so they can never collide with a pop.
  assign wr_acc   = wr_en && (state == IDLE) && (count != DEPTH_C);
  assign send_acc = send && (state == IDLE) && (count != '0);
  assign pop      = (state == STREAM) && (sent != len);
  assign head     = mem[rd_ptr];
  assign full     = (count == DEPTH_C) | busy;

  // FIFO storage: no reset needed, occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + AW'(1);
      count  <= count + CW'(1);
    end else if (pop) begin
      rd_ptr <= rd_ptr + AW'(1);
      count  <= count - CW'(1);
    end
  end

  // Frame control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      start        <= 1'b0;
      data_out     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      len          <= '0;
      sent         <= '0;
      tcnt         <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (send_acc) begin
            len   <= count;
            sent  <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (pop) begin
            data_out <= head;
            start    <= 1'b1;
            sent     <= sent + CW'(1);
          end else begin
            // data_out keeps the last word once start drops
            start <= 1'b0;
            tcnt  <= '0;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_in) begin
            result       <= max_in;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else if (tcnt == TO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAX_STREAM_TX_SELF_CHECK_EN
  logic [W-1:0] trk_max;

  // Track the max of words actually sent and compare it with the consumer's answer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_max <= '0;
      chk_err <= 1'b0;
    end else begin
      if (send_acc) trk_max <= '0;
      else if (pop && (head > trk_max)) trk_max <= head;
      if ((state == WAIT_DONE) && done_in && (max_in != trk_max)) chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule
